pipe_watchdog: RTL and testbench

Synthesizable pipeline health monitor for the WISC pipeline. It gathers per-stage error flags, watches retirement progress for deadlock, and tracks halt/drain completion. It drives the single-bit `err` consumed by the clock/reset generator, which stops simulation on a rising clock edge when `err` is high. It also exports `done` and a cause code so the bench can separate clean halts from faults.

---
 rtl/pipe_wd_pkg.sv | 17 +
 rtl/wd_sat_counter.sv | 25 ++
 rtl/pipe_watchdog.sv | 156 +++++++++++++++
 tb/tb_pipe_watchdog.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_wd_pkg.sv
// Shared types for the WISC pipeline watchdog.
// FSM state encoding and fault cause codes.
package pipe_wd_pkg;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED,
        FAULT
    } wd_state_e;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_STAGE   = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;
    localparam logic [1:0] CAUSE_PROTO   = 2'd3;

endpackage

// File: rtl/wd_sat_counter.sv
// Saturating up-counter with sync clear/enable and
// an equality compare against a threshold.
module wd_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] thresh,
    output logic [W-1:0] count,
    output logic         hit
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign hit = (count == thresh);

endmodule

// File: rtl/pipe_watchdog.sv
// Pipeline health monitor: stage errors, retire deadlock, halt drain.
// Build with PIPE_WATCHDOG_STATS_EN for cycle/retire statistics.
module pipe_watchdog
    import pipe_wd_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int TIMEOUT   = 64,
    parameter int DRAIN_CYC = 4,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] stage_err,
    input  logic               retire,
    input  logic               halt_retire,
    output logic               err,
    output logic               done,
    output logic [1:0]         cause,
    output logic [NUM_SRC-1:0] err_src
`ifdef PIPE_WATCHDOG_STATS_EN
   ,output logic [31:0]        cycle_count,
    output logic [31:0]        retire_count
`endif
);

    localparam logic [CNT_W-1:0] IDLE_TH  = CNT_W'(TIMEOUT - 1);
    localparam logic [7:0]       DRAIN_TH = 8'(DRAIN_CYC - 1);

    wd_state_e          state, state_n;
    logic [1:0]         cause_n;
    logic [NUM_SRC-1:0] src_n;
    logic               idle_clr, idle_en, idle_hit;
    logic               drain_clr, drain_en, drain_hit;
    logic [CNT_W-1:0]   idle_cnt;
    logic [7:0]         drain_cnt;
    logic               any_err;

    assign any_err = |stage_err;

    wd_sat_counter #(.W(CNT_W)) u_idle (
        .clk    (clk),
        .rst    (rst),
        .clr    (idle_clr),
        .en     (idle_en),
        .thresh (IDLE_TH),
        .count  (idle_cnt),
        .hit    (idle_hit)
    );

    wd_sat_counter #(.W(8)) u_drain (
        .clk    (clk),
        .rst    (rst),
        .clr    (drain_clr),
        .en     (drain_en),
        .thresh (DRAIN_TH),
        .count  (drain_cnt),
        .hit    (drain_hit)
    );

    // Priority: stage error, protocol, timeout, then normal progress.
    always_comb begin
        state_n   = state;
        cause_n   = cause;
        src_n     = err_src;
        idle_clr  = 1'b0;
        idle_en   = 1'b0;
        drain_clr = 1'b0;
        drain_en  = 1'b0;
        unique case (state)
            RUN: begin
                if (any_err) begin
                    state_n = FAULT;
                    cause_n = CAUSE_STAGE;
                    src_n   = stage_err;
                end else if (halt_retire && !retire) begin
                    state_n = FAULT;
                    cause_n = CAUSE_PROTO;
                    src_n   = '0;
                end else if (!retire && idle_hit) begin
                    state_n = FAULT;
                    cause_n = CAUSE_TIMEOUT;
                    src_n   = '0;
                end else if (retire && halt_retire) begin
                    state_n   = DRAIN;
                    drain_clr = 1'b1;
                    idle_clr  = 1'b1;
                end else if (retire) begin
                    idle_clr = 1'b1;
                end else begin
                    idle_en = 1'b1;
                end
            end
            DRAIN, HALTED: begin
                if (any_err) begin
                    state_n = FAULT;
                    cause_n = CAUSE_STAGE;
                    src_n   = stage_err;
                end else if (retire) begin
                    state_n = FAULT;
                    cause_n = CAUSE_PROTO;
                    src_n   = '0;
                end else if (state == DRAIN) begin
                    drain_en = 1'b1;
                    if (drain_hit) state_n = HALTED;
                end
            end
            FAULT: ;
            default: state_n = FAULT;
        endcase
    end

    // done lags the HALTED transition by one cycle; err tracks FAULT entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            err     <= 1'b0;
            done    <= 1'b0;
            cause   <= CAUSE_NONE;
            err_src <= '0;
        end else begin
            state   <= state_n;
            err     <= (state_n == FAULT);
            done    <= (state == HALTED) && (state_n == HALTED);
            cause   <= cause_n;
            err_src <= src_n;
        end
    end

`ifdef PIPE_WATCHDOG_STATS_EN
    logic active;
    logic cyc_hit, ret_hit;

    assign active = (state == RUN) || (state == DRAIN);

    wd_sat_counter #(.W(32)) u_cyc (
        .clk    (clk),
        .rst    (rst),
        .clr    (1'b0),
        .en     (active),
        .thresh ('1),
        .count  (cycle_count),
        .hit    (cyc_hit)
    );

    wd_sat_counter #(.W(32)) u_ret (
        .clk    (clk),
        .rst    (rst),
        .clr    (1'b0),
        .en     (active && retire),
        .thresh ('1),
        .count  (retire_count),
        .hit    (ret_hit)
    );
`endif

endmodule

// File: tb/tb_pipe_watchdog.sv
// Randomized + directed check of pipe_watchdog against a
// cycle-count reference model.
module tb_pipe_watchdog;

    localparam int NUM_SRC   = 4;
    localparam int TIMEOUT   = 64;
    localparam int DRAIN_CYC = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_SRC-1:0] stage_err;
    logic               retire;
    logic               halt_retire;
    logic               err;
    logic               done;
    logic [1:0]         cause;
    logic [NUM_SRC-1:0] err_src;
`ifdef PIPE_WATCHDOG_STATS_EN
    logic [31:0]        cycle_count;
    logic [31:0]        retire_count;
`endif

    pipe_watchdog #(
        .NUM_SRC   (NUM_SRC),
        .TIMEOUT   (TIMEOUT),
        .DRAIN_CYC (DRAIN_CYC),
        .CNT_W     (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stage_err    (stage_err),
        .retire       (retire),
        .halt_retire  (halt_retire),
        .err          (err),
        .done         (done),
        .cause        (cause),
        .err_src      (err_src)
`ifdef PIPE_WATCHDOG_STATS_EN
       ,.cycle_count  (cycle_count),
        .retire_count (retire_count)
`endif
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    // Reference model: idle run length, edges since halt, fault record.
    int         m_idle;
    int         m_age;
    bit         m_fault;
    int         m_cause;
    logic [3:0] m_src;
    int         m_cyc;
    int         m_ret;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic m_trip(input int c, input logic [3:0] s);
        m_fault = 1'b1;
        m_cause = c;
        m_src   = s;
    endtask

    task automatic model_step(input logic r, input logic rr,
                              input logic hr, input logic [3:0] se);
        bit act;
        if (r) begin
            m_idle = 0; m_age = -1; m_fault = 0;
            m_cause = 0; m_src = '0; m_cyc = 0; m_ret = 0;
            return;
        end
        act = !m_fault && (m_age < DRAIN_CYC);
        if (act) begin
            m_cyc++;
            if (rr) m_ret++;
        end
        if (m_fault) return;
        if (se != '0) m_trip(1, se);
        else if (m_age >= 0) begin
            if (rr) m_trip(3, '0);
            else m_age++;
        end
        else if (hr && !rr) m_trip(3, '0);
        else if (!rr && (m_idle + 1 == TIMEOUT)) m_trip(2, '0);
        else if (rr && hr) m_age = 0;
        else m_idle = rr ? 0 : m_idle + 1;
    endtask

    task automatic cyc(input logic r, input logic rr,
                       input logic hr, input logic [3:0] se);
        rst = r; retire = rr; halt_retire = hr; stage_err = se;
        @(posedge clk);
        model_step(r, rr, hr, se);
        @(negedge clk);
    endtask

    task automatic check_all();
        chk("err", 32'(err), 32'(m_fault));
        chk("done", 32'(done),
            32'(!m_fault && (m_age >= DRAIN_CYC + 1)));
        chk("cause", 32'(cause), 32'(m_cause));
        chk("err_src", 32'(err_src), 32'(m_src));
`ifdef PIPE_WATCHDOG_STATS_EN
        chk("cycle_count", cycle_count, 32'(m_cyc));
        chk("retire_count", retire_count, 32'(m_ret));
`endif
    endtask

    task automatic run(input int n, input logic rr,
                       input logic hr, input logic [3:0] se);
        repeat (n) begin
            cyc(1'b0, rr, hr, se);
            check_all();
        end
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            cyc(1'b1, 1'b0, 1'b0, '0);
            check_all();
        end
    endtask

    initial begin
        int p_ret;
        int r;
        logic rr, hr;
        logic [3:0] se;
        rst = 1'b1; retire = 1'b0; halt_retire = 1'b0; stage_err = '0;
        @(negedge clk);

        // Clean program
        do_reset(2);
        chk("rst_err", 32'(err), 0);
        chk("rst_cause", 32'(cause), 0);
        run(10, 1'b1, 1'b0, '0);
        run(1, 1'b1, 1'b1, '0);
        run(4, 1'b0, 1'b0, '0);
        chk("done_not_yet", 32'(done), 0);
        run(1, 1'b0, 1'b0, '0);
        chk("done_at_5", 32'(done), 1);
        run(3, 1'b0, 1'b0, '0);
        chk("clean_err", 32'(err), 0);
        chk("clean_cause", 32'(cause), 0);
`ifdef PIPE_WATCHDOG_STATS_EN
        chk("clean_retires", retire_count, 11);
`endif

        // Reset recovery from HALTED, then retire in HALTED faults
        do_reset(1);
        chk("rec_done", 32'(done), 0);
        run(3, 1'b1, 1'b0, '0);
        run(1, 1'b1, 1'b1, '0);
        run(7, 1'b0, 1'b0, '0);
        run(1, 1'b1, 1'b0, '0);
        chk("halted_ret_cause", 32'(cause), 3);
        chk("halted_ret_done", 32'(done), 0);

        // Deadlock
        do_reset(1);
        chk("rec_fault_err", 32'(err), 0);
        run(63, 1'b0, 1'b0, '0);
        chk("to_pre", 32'(err), 0);
        run(1, 1'b0, 1'b0, '0);
        chk("to_err", 32'(err), 1);
        chk("to_cause", 32'(cause), 2);
        chk("to_src", 32'(err_src), 0);
        run(4, 1'b1, 1'b0, '0);

        // Retire on the threshold cycle prevents the timeout
        do_reset(1);
        run(63, 1'b0, 1'b0, '0);
        run(1, 1'b1, 1'b0, '0);
        chk("thr_ret_err", 32'(err), 0);
        run(62, 1'b0, 1'b0, '0);
        run(1, 1'b1, 1'b0, '0);
        run(10, 1'b0, 1'b0, '0);

        // Stage error, held after it drops
        do_reset(1);
        run(3, 1'b1, 1'b0, '0);
        run(1, 1'b1, 1'b0, 4'b0100);
        run(5, 1'b0, 1'b0, '0);
        chk("se_cause", 32'(cause), 1);
        chk("se_src", 32'(err_src), 4'b0100);

        // Stage error with halt
        do_reset(1);
        run(2, 1'b1, 1'b0, '0);
        run(1, 1'b1, 1'b1, 4'b0001);
        run(8, 1'b0, 1'b0, '0);
        chk("se_halt_done", 32'(done), 0);
        chk("se_halt_cause", 32'(cause), 1);

        // Retire two cycles after halt
        do_reset(1);
        run(1, 1'b1, 1'b1, '0);
        run(1, 1'b0, 1'b0, '0);
        run(1, 1'b1, 1'b0, '0);
        chk("drain_ret_cause", 32'(cause), 3);

        // halt_retire without retire
        do_reset(1);
        run(2, 1'b1, 1'b0, '0);
        run(1, 1'b0, 1'b1, '0);
        chk("bare_halt_cause", 32'(cause), 3);

        // Randomized segments
        for (int s = 0; s < 40; s++) begin
            do_reset(1 + (s % 2));
            r = $urandom_range(0, 3);
            p_ret = (r == 0) ? 0 : (r == 1) ? 2 : (r == 2) ? 50 : 90;
            for (int c = 0; c < 200; c++) begin
                rr = ($urandom_range(0, 99) < p_ret);
                hr = rr ? ($urandom_range(0, 39) == 0)
                        : ($urandom_range(0, 299) == 0);
                se = ($urandom_range(0, 149) == 0) ? 4'($urandom) : '0;
                run(1, rr, hr, se);
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
